// File: rtl/alu_pkg.sv
// Shared op codes and FSM state encoding for the multi-cycle execute stage.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_NOP = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [3:0] ALU_DIV = 4'b1001;
  localparam logic [3:0] ALU_XOR = 4'b1010;
  localparam logic [3:0] ALU_SLL = 4'b1100;
  localparam logic [3:0] ALU_SRL = 4'b1101;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } alu_state_e;

endpackage

// File: rtl/alu_muldiv_core.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// lo_o/hi_o present the result of the iteration taking place at the coming edge.
module alu_muldiv_core #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] lo_o,
  output logic [Width-1:0] hi_o,
  output logic             last_iter_o
);

  localparam int unsigned CntW = $clog2(Width);

  logic [Width-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic             is_div_q, is_div_d, active_q, active_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [Width:0]   mul_sum;
  logic [Width:0]   div_shifted;
  logic [Width-1:0] div_trial;
  logic             div_fits;
  logic [Width-1:0] hi_step, lo_step;
  logic             last_iter;

  always_comb begin
    // Multiply: {hi, lo} is the partial product with the multiplier in lo, shifting right.
    mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
    // Divide: {hi, lo} is remainder:dividend, shifting left; quotient bits enter lo.
    div_shifted = {hi_q, lo_q[Width-1]};
    div_fits    = div_shifted >= {1'b0, opnd_q};
    div_trial   = div_shifted[Width-1:0] - opnd_q;
    if (is_div_q) begin
      hi_step = div_fits ? div_trial : div_shifted[Width-1:0];
      lo_step = {lo_q[Width-2:0], div_fits};
    end else begin
      hi_step = mul_sum[Width:1];
      lo_step = {mul_sum[0], lo_q[Width-1:1]};
    end
  end

  assign last_iter = active_q && (cnt_q == CntW'(Width - 1));

  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      hi_d     = '0;
      lo_d     = a_i;
      opnd_d   = b_i;
      is_div_d = is_div_i;
      active_d = 1'b1;
      cnt_d    = '0;
    end else if (active_q) begin
      hi_d  = hi_step;
      lo_d  = lo_step;
      cnt_d = cnt_q + 1'b1;
      if (last_iter) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

  assign lo_o        = lo_step;
  assign hi_o        = hi_step;
  assign last_iter_o = last_iter;

endmodule

// File: rtl/alu_multicycle_exec.sv
// Execute stage: single-cycle ALU ops plus iterative mult/div behind a start/busy/done handshake.
module alu_multicycle_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [SHW-1:0]   alu_shamt,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] alu_hi,
  output logic             alu_zero,
  output logic             alu_busy,
  output logic             alu_done
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d;
  logic             zero_q, zero_d, done_q, done_d;
  logic [WIDTH-1:0] simple_res;
  logic             core_start;
  logic [WIDTH-1:0] core_lo, core_hi;
  logic             core_last;

  always_comb begin
    case (alu_op)
      ALU_AND: simple_res = alu_a & alu_b;
      ALU_OR:  simple_res = alu_a | alu_b;
      ALU_ADD: simple_res = alu_a + alu_b;
      ALU_SUB: simple_res = alu_a - alu_b;
      ALU_XOR: simple_res = alu_a ^ alu_b;
      ALU_SLL: simple_res = alu_b << alu_shamt;
      ALU_SRL: simple_res = alu_b >> alu_shamt;
      default: simple_res = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    hi_d       = hi_q;
    zero_d     = zero_q;
    done_d     = 1'b0;
    core_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (alu_start) begin
          if (alu_op == ALU_MUL) begin
            core_start = 1'b1;
            state_d    = StMul;
          end else if (alu_op == ALU_DIV) begin
            if (alu_b == '0) begin
              result_d = '1;
              hi_d     = alu_a;
              done_d   = 1'b1;
            end else begin
              core_start = 1'b1;
              state_d    = StDiv;
            end
          end else begin
            result_d = simple_res;
            hi_d     = '0;
            done_d   = 1'b1;
          end
        end
      end
      StMul, StDiv: begin
        if (core_last) begin
          result_d = core_lo;
          hi_d     = core_hi;
          done_d   = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (done_d) zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  alu_muldiv_core #(
    .Width(WIDTH)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .start_i    (core_start),
    .is_div_i   (alu_op == ALU_DIV),
    .a_i        (alu_a),
    .b_i        (alu_b),
    .lo_o       (core_lo),
    .hi_o       (core_hi),
    .last_iter_o(core_last)
  );

  assign alu_result = result_q;
  assign alu_hi     = hi_q;
  assign alu_zero   = zero_q;
  assign alu_done   = done_q;
  assign alu_busy   = (state_q == StMul) || (state_q == StDiv);

endmodule
